// File: rtl/fpdiv_ctrl.sv
// Start/done sequencer for the Goldschmidt fpdiv datapath: drives operand/factor
// selects and register enables for IA multiply, ITERS refinement pairs, then remainder.
module fpdiv_ctrl #(
  parameter int ITERS = 5,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  output logic [1:0]    sel_mux4,
  output logic [1:0]    sel_mux3,
  output logic          en_a,
  output logic          en_b,
  output logic          en_rem,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] iter
);

  // state    | meaning
  // S_IDLE   | waiting for start
  // S_NUM_IA | numerator * initial approximation into A
  // S_DEN_IA | denominator * initial approximation into B
  // S_ITER_N | A <= A * C for refinement iteration iter
  // S_ITER_D | B <= B * C for refinement iteration iter
  // S_REM    | remainder / rounding stage load
  // S_DONE   | quotient and remainder valid for one cycle
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_NUM_IA = 3'd1,
    S_DEN_IA = 3'd2,
    S_ITER_N = 3'd3,
    S_ITER_D = 3'd4,
    S_REM    = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  localparam logic [CW-1:0] LAST_ITER = CW'(ITERS - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          if (start) state_d = S_NUM_IA;
        end
        S_NUM_IA: state_d = S_DEN_IA;
        S_DEN_IA: begin
          cnt_d   = '0;
          state_d = S_ITER_N;
        end
        S_ITER_N: state_d = S_ITER_D;
        S_ITER_D: begin
          if (cnt_q == LAST_ITER) begin
            cnt_d   = '0;
            state_d = S_REM;
          end else begin
            cnt_d   = cnt_q + CW'(1);
            state_d = S_ITER_N;
          end
        end
        S_REM:  state_d = S_DONE;
        S_DONE: state_d = S_IDLE;
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Moore decode; the unused encoding yields all-zero outputs while it recovers.
  always_comb begin
    sel_mux4 = 2'b00;
    sel_mux3 = 2'b00;
    en_a     = 1'b0;
    en_b     = 1'b0;
    en_rem   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    iter     = '0;
    case (state_q)
      S_NUM_IA: begin
        en_a = 1'b1;
        busy = 1'b1;
      end
      S_DEN_IA: begin
        sel_mux4 = 2'b01;
        en_b     = 1'b1;
        busy     = 1'b1;
      end
      S_ITER_N: begin
        sel_mux4 = 2'b10;
        sel_mux3 = 2'b01;
        en_a     = 1'b1;
        busy     = 1'b1;
        iter     = cnt_q;
      end
      S_ITER_D: begin
        sel_mux4 = 2'b11;
        sel_mux3 = 2'b01;
        en_b     = 1'b1;
        busy     = 1'b1;
        iter     = cnt_q;
      end
      S_REM: begin
        sel_mux4 = 2'b10;
        sel_mux3 = 2'b10;
        en_rem   = 1'b1;
        busy     = 1'b1;
      end
      S_DONE: begin
        sel_mux4 = 2'b10;
        sel_mux3 = 2'b10;
        busy     = 1'b1;
        done     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fpdiv_ctrl.sv
// Scoreboarded bench for fpdiv_ctrl with ITERS = 5, 1 and 15 instances.
module tb_fpdiv_ctrl;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          abort;
  logic          st   [3];
  logic [1:0]    s4   [3];
  logic [1:0]    s3   [3];
  logic          ea   [3];
  logic          eb   [3];
  logic          er   [3];
  logic          bz   [3];
  logic          dn   [3];
  logic [CW-1:0] it   [3];

  int assert_cnt = 0;
  int fail_cnt   = 0;
  logic [12:0] sbq [$];

  always #5 clk = ~clk;

  fpdiv_ctrl #(.ITERS(5), .CW(CW)) u_i5 (
    .clk(clk), .reset(reset), .start(st[0]), .abort(abort),
    .sel_mux4(s4[0]), .sel_mux3(s3[0]), .en_a(ea[0]), .en_b(eb[0]), .en_rem(er[0]),
    .busy(bz[0]), .done(dn[0]), .iter(it[0]));
  fpdiv_ctrl #(.ITERS(1), .CW(CW)) u_i1 (
    .clk(clk), .reset(reset), .start(st[1]), .abort(abort),
    .sel_mux4(s4[1]), .sel_mux3(s3[1]), .en_a(ea[1]), .en_b(eb[1]), .en_rem(er[1]),
    .busy(bz[1]), .done(dn[1]), .iter(it[1]));
  fpdiv_ctrl #(.ITERS(15), .CW(CW)) u_i15 (
    .clk(clk), .reset(reset), .start(st[2]), .abort(abort),
    .sel_mux4(s4[2]), .sel_mux3(s3[2]), .en_a(ea[2]), .en_b(eb[2]), .en_rem(er[2]),
    .busy(bz[2]), .done(dn[2]), .iter(it[2]));

  // {sel_mux4, sel_mux3, en_a, en_b, en_rem, busy, done, iter}
  function automatic logic [12:0] obs(input int k);
    return {s4[k], s3[k], ea[k], eb[k], er[k], bz[k], dn[k], it[k]};
  endfunction

  function automatic logic [12:0] ev(input logic [1:0] m4, input logic [1:0] m3,
                                     input logic a, input logic b, input logic r,
                                     input logic bsy, input logic dne, input logic [3:0] i);
    return {m4, m3, a, b, r, bsy, dne, i};
  endfunction

  function automatic logic [12:0] pop_exp();
    if (sbq.size() == 0) return 13'bx;
    return sbq.pop_front();
  endfunction

  task automatic push_idle();
    sbq.push_back(ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 4'd0));
  endtask

  // Expected cycles NUM_IA .. DONE for one division of n refinement iterations.
  task automatic push_seq(input int n);
    sbq.push_back(ev(2'b00, 2'b00, 1, 0, 0, 1, 0, 4'd0));
    sbq.push_back(ev(2'b01, 2'b00, 0, 1, 0, 1, 0, 4'd0));
    for (int i = 0; i < n; i++) begin
      sbq.push_back(ev(2'b10, 2'b01, 1, 0, 0, 1, 0, 4'(i)));
      sbq.push_back(ev(2'b11, 2'b01, 0, 1, 0, 1, 0, 4'(i)));
    end
    sbq.push_back(ev(2'b10, 2'b10, 0, 0, 1, 1, 0, 4'd0));
    sbq.push_back(ev(2'b10, 2'b10, 0, 0, 0, 1, 1, 4'd0));
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      for (int k = 0; k < 3; k++) begin
        assert_cnt++;
        if ($countones({ea[k], eb[k], er[k]}) > 1) begin
          fail_cnt++;
          $display("FAIL onehot inst%0d: enables a/b/rem=%b%b%b, at most one required",
                   k, ea[k], eb[k], er[k]);
        end
      end
    end
  end

  task automatic test_reset();
    logic [12:0] got;
    reset = 1'b0;
    abort = 1'b0;
    for (int k = 0; k < 3; k++) st[k] = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      got = obs(k);
      assert_cnt++;
      if (got !== 13'd0) begin
        fail_cnt++;
        $display("FAIL reset_held inst%0d: got %h expected %h", k, got, 13'd0);
      end
    end
    reset = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      got = obs(k);
      assert_cnt++;
      if (got !== 13'd0) begin
        fail_cnt++;
        $display("FAIL reset_idle inst%0d: got %h expected %h", k, got, 13'd0);
      end
    end
  endtask

  task automatic test_sequence(input int k, input int n);
    logic [12:0] got, exp;
    int done_at = -1;
    sbq.delete();
    push_seq(n);
    push_idle();
    @(negedge clk) st[k] = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 2 * n + 5; c++) begin
      got = obs(k);
      exp = pop_exp();
      if (dn[k] === 1'b1 && done_at < 0) done_at = c;
      assert_cnt++;
      if (got !== exp) begin
        fail_cnt++;
        $display("FAIL seq_iters%0d cycle %0d: got %h expected %h", n, c, got, exp);
      end
      @(negedge clk) st[k] = 1'b0;
      @(posedge clk); #1;
    end
    assert_cnt++;
    if (done_at !== 2 * n + 4) begin
      fail_cnt++;
      $display("FAIL latency_iters%0d: done at cycle %0d expected %0d", n, done_at, 2 * n + 4);
    end
  endtask

  task automatic test_start_ignored();
    logic [12:0] got, exp;
    int ndone = 0;
    sbq.delete();
    push_seq(5);
    push_idle();
    push_idle();
    @(negedge clk) st[0] = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 16; c++) begin
      got = obs(0);
      exp = pop_exp();
      if (dn[0] === 1'b1) ndone++;
      assert_cnt++;
      if (got !== exp) begin
        fail_cnt++;
        $display("FAIL start_ignored cycle %0d: got %h expected %h", c, got, exp);
      end
      @(negedge clk) st[0] = (c == 1 || c == 4 || c == 14);
      @(posedge clk); #1;
    end
    assert_cnt++;
    if (ndone != 1) begin
      fail_cnt++;
      $display("FAIL start_ignored_pulses: got %0d done pulses expected 1", ndone);
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] got, exp;
    int d1 = -1, d2 = -1;
    sbq.delete();
    push_seq(5);
    push_idle();
    push_seq(5);
    push_idle();
    push_idle();
    @(negedge clk) st[0] = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 31; c++) begin
      got = obs(0);
      exp = pop_exp();
      if (dn[0] === 1'b1) begin
        if (d1 < 0) d1 = c;
        else if (d2 < 0) d2 = c;
      end
      assert_cnt++;
      if (got !== exp) begin
        fail_cnt++;
        $display("FAIL back_to_back cycle %0d: got %h expected %h", c, got, exp);
      end
      @(negedge clk) st[0] = (c < 20);
      @(posedge clk); #1;
    end
    assert_cnt++;
    if (d1 < 0 || d2 < 0 || d2 - d1 != 15) begin
      fail_cnt++;
      $display("FAIL back_to_back_spacing: done at %0d and %0d, spacing 15 required", d1, d2);
    end
  endtask

  task automatic test_abort();
    logic [12:0] got, exp;
    sbq.delete();
    sbq.push_back(ev(2'b00, 2'b00, 1, 0, 0, 1, 0, 4'd0));
    sbq.push_back(ev(2'b01, 2'b00, 0, 1, 0, 1, 0, 4'd0));
    for (int i = 0; i < 2; i++) begin
      sbq.push_back(ev(2'b10, 2'b01, 1, 0, 0, 1, 0, 4'(i)));
      sbq.push_back(ev(2'b11, 2'b01, 0, 1, 0, 1, 0, 4'(i)));
    end
    sbq.push_back(ev(2'b10, 2'b01, 1, 0, 0, 1, 0, 4'd2));
    push_idle();
    push_idle();
    push_seq(5);
    push_idle();
    @(negedge clk) st[0] = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 24; c++) begin
      got = obs(0);
      exp = pop_exp();
      assert_cnt++;
      if (got !== exp) begin
        fail_cnt++;
        $display("FAIL abort cycle %0d: got %h expected %h", c, got, exp);
      end
      @(negedge clk);
      abort = (c == 7 || c == 8);
      st[0] = (c == 8 || c == 9);
      @(posedge clk); #1;
    end
    abort = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [12:0] got, exp;
    sbq.delete();
    sbq.push_back(ev(2'b00, 2'b00, 1, 0, 0, 1, 0, 4'd0));
    sbq.push_back(ev(2'b01, 2'b00, 0, 1, 0, 1, 0, 4'd0));
    sbq.push_back(ev(2'b10, 2'b01, 1, 0, 0, 1, 0, 4'd0));
    sbq.push_back(ev(2'b11, 2'b01, 0, 1, 0, 1, 0, 4'd0));
    @(negedge clk) st[0] = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 4; c++) begin
      got = obs(0);
      exp = pop_exp();
      assert_cnt++;
      if (got !== exp) begin
        fail_cnt++;
        $display("FAIL async_pre cycle %0d: got %h expected %h", c, got, exp);
      end
      if (c < 4) begin
        @(negedge clk) st[0] = 1'b0;
        @(posedge clk); #1;
      end
    end
    #2 reset = 1'b0;
    #1;
    got = obs(0);
    assert_cnt++;
    if (got !== 13'd0) begin
      fail_cnt++;
      $display("FAIL async_reset_midcycle: got %h expected %h", got, 13'd0);
    end
    @(negedge clk) reset = 1'b1;
    sbq.delete();
    push_seq(5);
    push_idle();
    @(negedge clk) st[0] = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 15; c++) begin
      got = obs(0);
      exp = pop_exp();
      assert_cnt++;
      if (got !== exp) begin
        fail_cnt++;
        $display("FAIL async_post cycle %0d: got %h expected %h", c, got, exp);
      end
      @(negedge clk) st[0] = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_sequence(0, 5);
    test_sequence(1, 1);
    test_sequence(2, 15);
    test_start_ignored();
    test_back_to_back();
    test_abort();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/fpdiv_ctrl.md
Name: fpdiv_ctrl

Overview:
- Sequencer for the Goldschmidt fpdiv datapath.
- Replaces hand-driven mux selects and register enables with a start/done-handshaked FSM.
- Drives sel_mux4, sel_mux3, en_a, en_b and en_rem each cycle: initial-approximation multiply, ITERS refinement pairs, then the remainder/rounding cycle.
- Sits directly upstream of fpdiv; its outputs connect 1:1 to the fpdiv control inputs.

Parameters:
ITERS, 5, number of refinement iterations (N/D multiply pairs using the C register); legal range 1..15
CW, 4, iteration counter width; must satisfy 2**CW > ITERS

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  request a new division; sampled only in IDLE
abort  input  1  synchronous flush; returns to IDLE from any state
sel_mux4  output  2  fpdiv multiplier operand select (00 num*IA, 01 den*IA, 10 num*C, 11 den*C)
sel_mux3  output  2  fpdiv factor select (00 IA, 01 C register, 10 remainder path)
en_a  output  1  load numerator/quotient register A
en_b  output  1  load denominator register B
en_rem  output  1  load remainder register / rounding stage
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse: quotient and remainder registers valid
iter  output  CW  current refinement iteration index, 0 outside ITER states

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; sel_mux4=00, sel_mux3=00, en_a=0, en_b=0, en_rem=0, busy=0, done=0, iter=0.
  - Reset asserted mid-operation aborts immediately; no partial enables persist after reset.
- Outputs are Moore, decoded from the registered state and counter only; no combinational path from start/abort to any output.
- States and per-state outputs (values hold for the whole cycle):
  - IDLE: all enables 0, selects 00. start=1 -> NUM_IA.
  - NUM_IA: sel_mux4=00, sel_mux3=00, en_a=1. -> DEN_IA.
  - DEN_IA: sel_mux4=01, sel_mux3=00, en_b=1. Clear counter. -> ITER_N.
  - ITER_N: sel_mux4=10, sel_mux3=01, en_a=1. -> ITER_D.
  - ITER_D: sel_mux4=11, sel_mux3=01, en_b=1.
    - If counter==ITERS-1 -> REM.
    - Else increment counter and -> ITER_N.
  - REM: sel_mux4=10, sel_mux3=10, en_a=0, en_b=0, en_rem=1. -> DONE.
  - DONE: done=1, enables 0, selects hold the REM values (10/10) so fpdiv output is stable. -> IDLE.
- Enable exclusivity: at most one of en_a, en_b, en_rem is high in any cycle.
- iter output: counter value in ITER_N/ITER_D; 0 in all other states.
- Latency: start sampled high in IDLE at edge k gives done high in cycle k+2*ITERS+4, i.e. 14 cycles after the start edge for ITERS=5. busy is high from cycle k+1 through the DONE cycle inclusive.
- start outside IDLE (busy=1, including DONE) is ignored; no queuing. start held high continuously gives back-to-back operations separated by exactly one IDLE cycle.
- abort=1 in any non-IDLE state: next state IDLE, counter cleared, no done pulse.
- abort has priority over start. abort and start both high in IDLE: stay IDLE.
- Illegal/unreachable state encodings recover to IDLE on the next edge with all enables 0.

Test Plan:
- Reset then single start pulse, ITERS=5: sel_mux4 sequence 00,01,10,11 (x5),10; sel_mux3 sequence 00,00,01 (x10),10; en_a/en_b alternate starting en_a; en_rem=1 exactly in cycle 13; done=1 in cycle 14; busy=0 in cycle 15.
- Counter check, ITERS=1 and ITERS=15: done arrives 6 and 34 cycles after the start edge respectively. iter counts 0..ITERS-1, each value held for exactly two cycles.
- start re-asserted in NUM_IA, ITER_D and DONE: ignored, single done pulse; start held high continuously -> done pulses exactly 15 cycles apart (ITERS=5).
- abort asserted in ITER_N with iter=2: next cycle IDLE, all enables 0, iter=0, no done; a following start runs a full clean 14-cycle sequence.
- reset driven low asynchronously mid-cycle during ITER_D: outputs go to reset values before the next clk edge; release plus start gives a normal sequence.
- Integrated with fpdiv: inputNum=0x8683F7FF, inputDenom=0xC07F3FFF, rm=1 -> final_ans on the done cycle equals the f32_div_rne reference quotient; one-hot enable assertion never fires.
